// File: rtl/maxpool2x2_wrb.sv
// maxpool2x2_wrb: 2x2 stride-2 max pooling of a raster conv stream, with optional ReLU.
// Each pooled word leaves with its packed per-channel SRAM write address.
module maxpool2x2_wrb #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int N_CH   = 4,
  parameter int ADDR_W = 12,
  parameter int RELU   = 1,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              frame_done,
  output logic [CH_W-1:0]   ch_idx
);
  localparam int HW  = IMG_W / 2;
  localparam int PIX = HW * (IMG_H / 2);
  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int LW  = (HW > 1) ? $clog2(HW) : 1;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic signed [DATA_W-1:0] hold, lb_rd, pix, mx_hold, mx_lb, res;
  logic signed [DATA_W-1:0] linebuf [HW];
  logic [LW-1:0] lb_idx;
  logic [DATA_W-1:0] f_data [2];
  logic [ADDR_W-1:0] f_addr [2];
  logic              f_last [2];
  logic              wp, rp;
  logic [1:0]        cnt;
  logic              in_fire, out_fire, push, last_col, last_row;
  logic [ADDR_W-1:0] push_addr;
  assign pix       = signed'(in_data);
  assign lb_idx    = LW'(col >> 1);
  assign lb_rd     = linebuf[lb_idx];
  assign mx_hold   = (hold > pix) ? hold : pix;
  assign mx_lb     = (lb_rd > pix) ? lb_rd : pix;
  assign res       = (RELU != 0 && mx_hold[DATA_W-1]) ? '0 : mx_hold;
  assign in_ready  = cnt != 2'd2;
  assign out_valid = cnt != 2'd0;
  assign out_data  = f_data[rp];
  assign out_addr  = f_addr[rp];
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign push      = in_fire && row[0] && col[0];
  assign last_col  = col == CW'(IMG_W - 1);
  assign last_row  = row == RW'(IMG_H - 1);
  assign push_addr = ADDR_W'(ch_idx) * ADDR_W'(PIX) + ADDR_W'(row >> 1) * ADDR_W'(HW) + ADDR_W'(col >> 1);
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      col        <= '0;
      row        <= '0;
      ch_idx     <= '0;
      hold       <= '0;
      wp         <= 1'b0;
      rp         <= 1'b0;
      cnt        <= 2'd0;
      f_data[0]  <= '0;
      f_data[1]  <= '0;
      f_addr[0]  <= '0;
      f_addr[1]  <= '0;
      f_last[0]  <= 1'b0;
      f_last[1]  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_fire && f_last[rp];
      if (in_fire) begin
        col <= last_col ? '0 : col + 1'b1;
        if (last_col) row <= last_row ? '0 : row + 1'b1;
        if (last_col && last_row) ch_idx <= (ch_idx == CH_W'(N_CH - 1)) ? '0 : ch_idx + 1'b1;
        if (!col[0]) hold <= row[0] ? mx_lb : pix;
      end
      if (push) begin
        f_data[wp] <= res;
        f_addr[wp] <= push_addr;
        f_last[wp] <= last_col && last_row;
        wp         <= ~wp;
      end
      if (out_fire) rp <= ~rp;
      cnt <= cnt + 2'(push) - 2'(out_fire);
    end
  end
  // Pairwise row max of the even row, consumed by the odd row below it.
  always_ff @(posedge clk) begin
    if (in_fire && !row[0] && col[0]) linebuf[lb_idx] <= mx_hold;
  end
endmodule

// File: tb/tb_maxpool2x2_wrb.sv
// tb_maxpool2x2_wrb: randomized and directed stimulus against a frame-array pooling model,
// run on a RELU=1 and a RELU=0 instance sharing one input stream.
module tb_maxpool2x2_wrb;
  localparam int DW = 16, IW = 4, IH = 4, NC = 2, AW = 12;
  logic clk = 0, reset = 0, clear = 0, in_valid = 0, out_ready = 0;
  logic [DW-1:0] in_data = '0;
  logic rdy1, rdy0, ov1, ov0, fd1, fd0;
  logic [DW-1:0] od1, od0;
  logic [AW-1:0] oa1, oa0;
  logic [0:0] ch1, ch0;
  maxpool2x2_wrb #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .N_CH(NC), .ADDR_W(AW), .RELU(1)) u1 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_addr(oa1), .frame_done(fd1), .ch_idx(ch1));
  maxpool2x2_wrb #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .N_CH(NC), .ADDR_W(AW), .RELU(0)) u0 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_addr(oa0), .frame_done(fd0), .ch_idx(ch0));
  always #5 clk = ~clk;
  typedef struct {logic [DW-1:0] d1; logic [DW-1:0] d0; int a; bit last;} ent_t;
  ent_t q[$];
  ent_t e;
  logic signed [DW-1:0] frame [IH][IW];
  logic signed [DW-1:0] m;
  int mr, mc, mch, n, passed, total, fd_cnt;
  bit exp_fd, armed, done;
  int lg_a[$];
  logic [DW-1:0] lg_d1[$], lg_d0[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask
  // Model: snapshot each frame in an array, pool each completed 2x2 window into a queue.
  always @(negedge clk) begin
    if (armed) begin
      chk("out_valid1", ov1, q.size() != 0);
      chk("out_valid0", ov0, q.size() != 0);
      chk("in_ready1", rdy1, q.size() < 2);
      chk("in_ready0", rdy0, q.size() < 2);
      chk("ch_idx1", ch1, mch);
      chk("ch_idx0", ch0, mch);
      chk("frame_done1", fd1, exp_fd);
      chk("frame_done0", fd0, exp_fd);
      if (q.size() != 0) begin
        chk("out_data1", od1, q[0].d1);
        chk("out_data0", od0, q[0].d0);
        chk("out_addr1", oa1, q[0].a);
        chk("out_addr0", oa0, q[0].a);
      end
    end
    if (fd1) fd_cnt++;
    if (!reset || clear) begin
      q.delete();
      mr = 0; mc = 0; mch = 0; exp_fd = 0; armed = 1;
    end else begin
      n = q.size();
      exp_fd = 0;
      if (ov1 && out_ready) begin
        lg_a.push_back(int'(oa1)); lg_d1.push_back(od1); lg_d0.push_back(od0);
      end
      if (n != 0 && out_ready) begin
        exp_fd = q[0].last;
        void'(q.pop_front());
      end
      if (in_valid && n < 2) begin
        frame[mr][mc] = in_data;
        if (mr % 2 == 1 && mc % 2 == 1) begin
          m = frame[mr-1][mc-1];
          if (frame[mr-1][mc] > m) m = frame[mr-1][mc];
          if (frame[mr][mc-1] > m) m = frame[mr][mc-1];
          if (frame[mr][mc] > m) m = frame[mr][mc];
          e.d0 = m;
          e.d1 = (m < 0) ? '0 : m;
          e.a = mch * (IW / 2) * (IH / 2) + (mr / 2) * (IW / 2) + mc / 2;
          e.last = (mr == IH - 1) && (mc == IW - 1);
          q.push_back(e);
        end
        if (mc == IW - 1) begin
          mc = 0;
          if (mr == IH - 1) begin mr = 0; mch = (mch + 1) % NC; end
          else mr++;
        end else mc++;
      end
    end
  end
  task automatic send(input logic [DW-1:0] v);
    int k = 0;
    in_valid = 1; in_data = v;
    @(negedge clk);
    while (!rdy1 && k < 100) begin k++; @(negedge clk); end
    if (k >= 100) chk("send_timeout", k, 0);
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic idle(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask
  task automatic check_ramp(input int b, input int abase, input string tag);
    logic [DW-1:0] exp_d [4];
    exp_d[0] = 5; exp_d[1] = 7; exp_d[2] = 13; exp_d[3] = 15;
    chk({tag, "_count"}, lg_a.size() - b, 4);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_data"}, lg_d1[b+i], exp_d[i]);
      chk({tag, "_addr"}, lg_a[b+i], abase + i);
    end
  endtask
  initial begin
    int b, f;
    passed = 0; total = 0; fd_cnt = 0; armed = 0; done = 0;
    idle(2);
    chk("rst_out_valid", ov1, 0);
    chk("rst_in_ready", rdy1, 1);
    chk("rst_ch_idx", ch1, 0);
    chk("rst_frame_done", fd1, 0);
    chk("rst_out_data", od1, 0);
    chk("rst_out_addr", oa1, 0);
    reset = 1; out_ready = 1;
    idle(1);
    b = lg_a.size(); f = fd_cnt;
    for (int i = 0; i < 16; i++) send(DW'(i));
    idle(4);
    check_ramp(b, 0, "ramp_ch0");
    chk("ramp_fd_pulses", fd_cnt - f, 1);
    chk("ramp_ch_next", ch1, 1);
    b = lg_a.size(); f = fd_cnt;
    for (int i = 0; i < 16; i++) send(16'hFFF9);
    idle(4);
    chk("neg_count", lg_a.size() - b, 4);
    for (int i = 0; i < 4; i++) begin
      chk("neg_relu1", lg_d1[b+i], 0);
      chk("neg_relu0", lg_d0[b+i], 16'hFFF9);
      chk("neg_addr", lg_a[b+i], 4 + i);
    end
    chk("neg_fd_pulses", fd_cnt - f, 1);
    chk("neg_ch_wrap", ch1, 0);
    b = lg_a.size();
    send(-16'sd3); send(-16'sd1); send(0); send(0);
    send(-16'sd8); send(-16'sd2);
    for (int i = 0; i < 10; i++) send(0);
    idle(4);
    chk("smax_raw", lg_d0[b], 16'hFFFF);
    chk("smax_relu", lg_d1[b], 0);
    chk("smax_addr", lg_a[b], 0);
    for (int i = 0; i < 16; i++) send(DW'(i * 3 - 20));
    idle(4);
    out_ready = 0;
    b = lg_a.size(); f = fd_cnt;
    for (int i = 0; i < 8; i++) send(DW'(i));
    idle(3);
    chk("stall_in_ready", rdy1, 0);
    chk("stall_out_valid", ov1, 1);
    chk("stall_head_addr", oa1, 0);
    chk("stall_head_data", od1, 5);
    out_ready = 1;
    for (int i = 8; i < 16; i++) send(DW'(i));
    idle(4);
    check_ramp(b, 0, "stall");
    chk("stall_fd_pulses", fd_cnt - f, 1);
    f = fd_cnt;
    for (int i = 0; i < 9; i++) send(DW'(i + 100));
    clear = 1;
    idle(1);
    clear = 0;
    chk("clr_out_valid", ov1, 0);
    chk("clr_ch_idx", ch1, 0);
    chk("clr_in_ready", rdy1, 1);
    idle(2);
    chk("clr_no_fd", fd_cnt - f, 0);
    b = lg_a.size();
    for (int i = 0; i < 16; i++) send(DW'(i));
    idle(4);
    check_ramp(b, 0, "clr_restart");
    fork
      begin
        for (int fr = 0; fr < 12; fr++)
          for (int i = 0; i < IW * IH; i++) begin
            send(DW'($urandom()));
            if ($urandom_range(1, 0) == 1) idle($urandom_range(2, 0));
          end
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(3, 0) != 0);
          idle(1);
        end
      end
    join
    out_ready = 1;
    idle(10);
    chk("final_drained", ov1, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
